// File: rtl/adc_spi_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : adc_spi_reader_if
//  Description : Bus between the ADC SPI reader and its surroundings: control
//                input, serial ADC pins and the parallel result with strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adc_spi_reader_if #(
    parameter int DATA_BITS = 16
);
    logic                 enable;
    logic                 adc_sdo;
    logic                 adc_cs_n;
    logic                 adc_sclk;
    logic [DATA_BITS-1:0] adc_data_out;
    logic                 data_valid;
    logic                 overrun;

    // Reader side: drives the SPI pins and the result bus.
    modport master (
        input  enable,
        input  adc_sdo,
        output adc_cs_n,
        output adc_sclk,
        output adc_data_out,
        output data_valid,
        output overrun
    );

    // Environment side: ADC pins plus the downstream consumer.
    modport slave (
        output enable,
        output adc_sdo,
        input  adc_cs_n,
        input  adc_sclk,
        input  adc_data_out,
        input  data_valid,
        input  overrun
    );
endinterface
`default_nettype wire

// File: rtl/adc_spi_reader.sv
`default_nettype none
// ============================================================================
//  Module      : adc_spi_reader
//  Description : Periodic SPI master for a serial ADC. A free-running sample
//                timer starts one conversion per period; the result is held
//                on a parallel bus with a one-cycle valid strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_spi_reader #(
    parameter int CLK_DIV       = 2,
    parameter int DATA_BITS     = 16,
    parameter int SAMPLE_PERIOD = 100
) (
    input  wire logic             clk,
    input  wire logic             reset,
    adc_spi_reader_if.master      bus
);

    localparam int TIMER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int DIV_W   = (CLK_DIV > 1)       ? $clog2(CLK_DIV)       : 1;
    localparam int BIT_W   = (DATA_BITS > 1)     ? $clog2(DATA_BITS)     : 1;

    localparam logic [TIMER_W-1:0] C_TIMER_LAST = TIMER_W'(SAMPLE_PERIOD - 1);
    localparam logic [DIV_W-1:0]   C_DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]   C_BIT_LAST   = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 cs_n_q, cs_n_d;
    logic                 sclk_q, sclk_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;

    logic                 start_tick;
    logic                 phase_end;

    assign start_tick = bus.enable && (timer_q == C_TIMER_LAST);
    assign phase_end  = (div_q == C_DIV_LAST);

    // Sample timer: wraps every SAMPLE_PERIOD cycles, parked at 0 while disabled.
    always_ff @(posedge clk) begin
        if (reset || !bus.enable || timer_q == C_TIMER_LAST) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TIMER_W'(1);
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic: frame sequencing, SCLK phases and MSB-first capture.
    // Sampling happens on the edge that raises SCLK, i.e. half a period after
    // the ADC moved SDO on the preceding falling edge.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        valid_d   = 1'b0;
        // Any tick outside IDLE (DONE included) is dropped and flagged.
        overrun_d = start_tick && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                if (start_tick) begin
                    state_d = S_SETUP;
                    cs_n_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    shift_d = '0;
                end
            end

            S_SETUP: begin
                if (phase_end) begin
                    state_d = S_SHIFT;
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    shift_d = {shift_q[DATA_BITS-2:0], bus.adc_sdo};
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            S_SHIFT: begin
                if (!phase_end) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else if (bit_q == C_BIT_LAST) begin
                        // Low phase of the last bit: all bits already captured.
                        state_d = S_DONE;
                        cs_n_d  = 1'b1;
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        sclk_d  = 1'b1;
                        shift_d = {shift_q[DATA_BITS-2:0], bus.adc_sdo};
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase
    end

    assign bus.adc_cs_n     = cs_n_q;
    assign bus.adc_sclk     = sclk_q;
    assign bus.adc_data_out = data_q;
    assign bus.data_valid   = valid_q;
    assign bus.overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_spi_reader
//  Description : Directed self-checking bench for adc_spi_reader. Instance A
//                uses default parameters; instance B uses SAMPLE_PERIOD=40 so
//                ticks land inside busy frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_spi_reader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   last_valid = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_spi_reader_if #(.DATA_BITS(16)) bus_a ();
    adc_spi_reader_if #(.DATA_BITS(16)) bus_b ();

    adc_spi_reader #(.CLK_DIV(2), .DATA_BITS(16), .SAMPLE_PERIOD(100)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    adc_spi_reader #(.CLK_DIV(2), .DATA_BITS(16), .SAMPLE_PERIOD(40)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // ADC models: each frame takes the next word from a queue, puts its MSB
    // on SDO when CS falls and moves to the next bit after each SCLK fall.
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    logic [15:0] word_a = 16'h0;
    logic [15:0] word_b = 16'h0;
    int          idx_a = 0;
    int          idx_b = 0;

    always @(negedge bus_a.adc_cs_n) begin
        word_a = 16'h0;
        if (q_a.size() > 0) word_a = q_a.pop_front();
        idx_a = 15;
        #1 bus_a.adc_sdo = word_a[15];
    end

    always @(negedge bus_a.adc_sclk) begin
        idx_a = idx_a - 1;
        #1 bus_a.adc_sdo = (idx_a >= 0) ? word_a[idx_a] : 1'b0;
    end

    always @(negedge bus_b.adc_cs_n) begin
        word_b = 16'h0;
        if (q_b.size() > 0) word_b = q_b.pop_front();
        idx_b = 15;
        #1 bus_b.adc_sdo = word_b[15];
    end

    always @(negedge bus_b.adc_sclk) begin
        idx_b = idx_b - 1;
        #1 bus_b.adc_sdo = (idx_b >= 0) ? word_b[idx_b] : 1'b0;
    end

    task automatic test_reset();
        int k;
        reset = 1'b1;
        bus_a.enable = 1'b1;
        bus_b.enable = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus_a.adc_cs_n !== 1'b1) $display("FAIL reset_cs_n: got %b expected 1", bus_a.adc_cs_n); else n_pass++;
        n_checks++; if (bus_a.adc_sclk !== 1'b0) $display("FAIL reset_sclk: got %b expected 0", bus_a.adc_sclk); else n_pass++;
        n_checks++; if (bus_a.adc_data_out !== 16'h0000) $display("FAIL reset_data: got %h expected 0000", bus_a.adc_data_out); else n_pass++;
        n_checks++; if (bus_a.data_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus_a.data_valid); else n_pass++;
        n_checks++; if (bus_a.overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", bus_a.overrun); else n_pass++;
        q_a.push_back(16'hA5C3);
        reset = 1'b0;
        // Counting the release cycle as the first, CS is low in the 101st cycle,
        // i.e. 100 negedges after the one where reset dropped.
        k = 0;
        while (bus_a.adc_cs_n !== 1'b0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        n_checks++; if (k != 100) $display("FAIL first_cs_fall: got %0d cycles expected 100", k); else n_pass++;
        n_checks++; if (bus_a.adc_sclk !== 1'b0) $display("FAIL sclk_at_cs_fall: got %b expected 0", bus_a.adc_sclk); else n_pass++;
    endtask

    task automatic test_single();
        int low = 1, rises = 0, run = 1, bad = 0, steps = 0;
        logic prev = 1'b0;
        while (bus_a.adc_cs_n === 1'b0 && steps < 200) begin
            @(negedge clk);
            steps++;
            if (bus_a.adc_cs_n === 1'b0) begin
                low++;
                if (bus_a.adc_sclk !== prev) begin
                    if (run != 2) bad++;
                    run = 1;
                    if (bus_a.adc_sclk === 1'b1) rises++;
                end else begin
                    run++;
                end
                prev = bus_a.adc_sclk;
            end
        end
        if (run != 2) bad++;
        n_checks++; if (low != 66) $display("FAIL cs_low_time: got %0d expected 66", low); else n_pass++;
        n_checks++; if (rises != 16) $display("FAIL sclk_rises: got %0d expected 16", rises); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL sclk_phase_len: got %0d bad phases expected 0", bad); else n_pass++;
        n_checks++; if (bus_a.adc_sclk !== 1'b0) $display("FAIL sclk_at_cs_rise: got %b expected 0", bus_a.adc_sclk); else n_pass++;
        n_checks++; if (bus_a.data_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", bus_a.data_valid); else n_pass++;
        n_checks++; if (bus_a.adc_data_out !== 16'hA5C3) $display("FAIL single_data: got %h expected a5c3", bus_a.adc_data_out); else n_pass++;
        last_valid = cyc;
        @(negedge clk);
        n_checks++; if (bus_a.data_valid !== 1'b0) $display("FAIL single_valid_width: got %b expected 0", bus_a.data_valid); else n_pass++;
        n_checks++; if (bus_a.adc_data_out !== 16'hA5C3) $display("FAIL single_hold: got %h expected a5c3", bus_a.adc_data_out); else n_pass++;
    endtask

    task automatic test_stream();
        logic [15:0] exp_w[3] = '{16'h0000, 16'hFFFF, 16'h8001};
        logic [15:0] held = 16'hA5C3;
        int steps, bad_hold;
        for (int i = 0; i < 3; i++) q_a.push_back(exp_w[i]);
        for (int i = 0; i < 3; i++) begin
            steps = 0;
            bad_hold = 0;
            while (bus_a.data_valid !== 1'b1 && steps < 300) begin
                @(negedge clk);
                steps++;
                if (bus_a.data_valid !== 1'b1 && bus_a.adc_data_out !== held) bad_hold++;
            end
            n_checks++; if (cyc - last_valid != 100) $display("FAIL stream_gap%0d: got %0d expected 100", i, cyc - last_valid); else n_pass++;
            n_checks++; if (bus_a.adc_data_out !== exp_w[i]) $display("FAIL stream_data%0d: got %h expected %h", i, bus_a.adc_data_out, exp_w[i]); else n_pass++;
            n_checks++; if (bad_hold != 0) $display("FAIL stream_hold%0d: got %0d changes expected 0", i, bad_hold); else n_pass++;
            held = exp_w[i];
            last_valid = cyc;
            @(negedge clk);
        end
    endtask

    task automatic test_enable_drop();
        int steps = 0, rises = 0, falls = 0, valids = 0;
        logic prev = 1'b0;
        q_a.push_back(16'h5A5A);
        while (bus_a.adc_cs_n !== 1'b0 && steps < 200) begin @(negedge clk); steps++; end
        steps = 0;
        while (rises < 6 && steps < 100) begin
            @(negedge clk);
            steps++;
            if (bus_a.adc_sclk === 1'b1 && prev === 1'b0) rises++;
            prev = bus_a.adc_sclk;
        end
        bus_a.enable = 1'b0;
        steps = 0;
        while (bus_a.data_valid !== 1'b1 && steps < 200) begin @(negedge clk); steps++; end
        n_checks++; if (bus_a.data_valid !== 1'b1) $display("FAIL drop_valid: got %b expected 1", bus_a.data_valid); else n_pass++;
        n_checks++; if (bus_a.adc_data_out !== 16'h5A5A) $display("FAIL drop_data: got %h expected 5a5a", bus_a.adc_data_out); else n_pass++;
        prev = bus_a.adc_cs_n;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus_a.adc_cs_n === 1'b0 && prev === 1'b1) falls++;
            if (bus_a.data_valid === 1'b1) valids++;
            prev = bus_a.adc_cs_n;
        end
        n_checks++; if (falls != 0) $display("FAIL drop_no_frame: got %0d cs falls expected 0", falls); else n_pass++;
        n_checks++; if (valids != 0) $display("FAIL drop_no_valid: got %0d pulses expected 0", valids); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int steps = 0, rises = 0, bad = 0;
        logic prev = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        n_checks++; if (bus_a.adc_data_out !== 16'h0000) $display("FAIL rmid_cleared: got %h expected 0000", bus_a.adc_data_out); else n_pass++;
        q_a.push_back(16'hDEAD);
        q_a.push_back(16'h1234);
        bus_a.enable = 1'b1;
        while (bus_a.adc_cs_n !== 1'b0 && steps < 200) begin @(negedge clk); steps++; end
        steps = 0;
        while (rises < 8 && steps < 100) begin
            @(negedge clk);
            steps++;
            if (bus_a.adc_sclk === 1'b1 && prev === 1'b0) rises++;
            prev = bus_a.adc_sclk;
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (bus_a.adc_cs_n !== 1'b1) $display("FAIL rmid_cs_n: got %b expected 1", bus_a.adc_cs_n); else n_pass++;
        n_checks++; if (bus_a.adc_sclk !== 1'b0) $display("FAIL rmid_sclk: got %b expected 0", bus_a.adc_sclk); else n_pass++;
        n_checks++; if (bus_a.data_valid !== 1'b0) $display("FAIL rmid_valid: got %b expected 0", bus_a.data_valid); else n_pass++;
        reset = 1'b0;
        steps = 0;
        while (bus_a.data_valid !== 1'b1 && steps < 300) begin
            if (bus_a.adc_data_out !== 16'h0000) bad++;
            @(negedge clk);
            steps++;
        end
        n_checks++; if (bad != 0) $display("FAIL rmid_data_held0: got %0d nonzero cycles expected 0", bad); else n_pass++;
        n_checks++; if (bus_a.data_valid !== 1'b1 || bus_a.adc_data_out !== 16'h1234)
            $display("FAIL rmid_next_frame: got valid=%b data=%h expected valid=1 data=1234", bus_a.data_valid, bus_a.adc_data_out);
        else n_pass++;
    endtask

    task automatic test_overrun();
        logic [15:0] exp_w[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        int nv = 0, ov = 0, bad_w = 0, bad_gap = 0, last_ov = -1, steps = 0;
        logic prev_ov = 1'b0;
        bus_a.enable = 1'b0;
        for (int i = 0; i < 4; i++) q_b.push_back(exp_w[i]);
        bus_b.enable = 1'b1;
        // Ticks every 40 cycles, frames take 68: every other tick is an overrun.
        while (nv < 4 && steps < 600) begin
            @(negedge clk);
            steps++;
            if (bus_b.overrun === 1'b1) begin
                ov++;
                if (prev_ov === 1'b1) bad_w++;
                if (last_ov >= 0 && cyc - last_ov != 80) bad_gap++;
                last_ov = cyc;
            end
            prev_ov = bus_b.overrun;
            if (bus_b.data_valid === 1'b1) begin
                n_checks++; if (bus_b.adc_data_out !== exp_w[nv]) $display("FAIL ovr_data%0d: got %h expected %h", nv, bus_b.adc_data_out, exp_w[nv]); else n_pass++;
                nv++;
            end
        end
        n_checks++; if (nv != 4) $display("FAIL ovr_frames: got %0d expected 4", nv); else n_pass++;
        n_checks++; if (ov != 4) $display("FAIL ovr_count: got %0d expected 4", ov); else n_pass++;
        n_checks++; if (bad_w != 0) $display("FAIL ovr_width: got %0d long pulses expected 0", bad_w); else n_pass++;
        n_checks++; if (bad_gap != 0) $display("FAIL ovr_spacing: got %0d bad gaps expected 0", bad_gap); else n_pass++;
        bus_b.enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_enable_drop();
        test_reset_mid();
        test_overrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
